// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8       = 6'd8;
    localparam logic [5:0] PRESCALE_16      = 6'd16;
    localparam logic [5:0] PRESCALE_32      = 6'd32;
    localparam logic [5:0] PRESCALE_DEFAULT = PRESCALE_16;

    // Sample point sits this many edges past mid-bit.
    localparam logic [5:0] SP_OFFSET = 6'd2;

    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
            default:                              return PRESCALE_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller; drives external edge counter, sampler and checkers.
// Optional UART_RX_ERR_STATUS_EN adds rx_status = {stop_err, parity_err} captured in DONE.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic [5:0] prescale,
    input  logic [4:0] edge_cnt,
    input  logic [3:0] bit_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       edge_cnt_en,
    output logic       cnt_clr,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid
`ifdef UART_RX_ERR_STATUS_EN
    ,
    output logic [1:0] rx_status
`endif
);

    rx_state_e  state;
    logic [5:0] prescale_l;
    logic       par_en_l;

    logic [4:0] sp_cnt;
    logic [4:0] eob_cnt;
    logic       at_sp;
    logic       at_eob;
    logic       last_data;

    always_comb begin
        sp_cnt    = 5'((prescale_l >> 1) + SP_OFFSET);
        eob_cnt   = 5'(prescale_l - 6'd1);
        at_sp     = (edge_cnt == sp_cnt);
        at_eob    = (edge_cnt == eob_cnt);
        last_data = (bit_cnt == 4'(DATA_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prescale_l <= PRESCALE_DEFAULT;
            par_en_l   <= 1'b0;
`ifdef UART_RX_ERR_STATUS_EN
            rx_status  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_in) begin
                        state      <= START;
                        prescale_l <= legal_prescale(prescale);
                        par_en_l   <= par_en;
                    end
                end
                START: begin
                    if (at_eob) begin
                        state <= strt_glitch ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (at_eob && last_data) begin
                        state <= par_en_l ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (at_eob) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (at_eob) begin
                        state <= DONE;
                    end
                end
                DONE: begin
`ifdef UART_RX_ERR_STATUS_EN
                    rx_status <= {stp_err, par_en_l & par_err};
`endif
                    // A low line here is the next start bit, so relatch config now.
                    if (rx_in) begin
                        state <= IDLE;
                    end else begin
                        state      <= START;
                        prescale_l <= legal_prescale(prescale);
                        par_en_l   <= par_en;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        edge_cnt_en = 1'b0;
        cnt_clr     = 1'b0;
        dat_samp_en = 1'b0;
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        data_valid  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
            end
            START: begin
                edge_cnt_en = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = at_sp;
            end
            DATA: begin
                edge_cnt_en = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = at_sp;
            end
            PARITY: begin
                edge_cnt_en = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = at_sp;
            end
            STOP: begin
                edge_cnt_en = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = at_sp;
            end
            DONE: begin
                cnt_clr    = 1'b1;
                data_valid = !stp_err && !(par_en_l && par_err);
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

endmodule
